// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and sizing helpers for the toggle req/ack CDC handshake
package cdc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_state_e;

  localparam int SYNC_STAGES_MIN = 2;

  // Width of a counter that must hold 0..timeout_cycles; never narrower than 1 bit.
  function automatic int cnt_width(input int timeout_cycles);
    if (timeout_cycles < 1) begin
      return 1;
    end
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// rtl/cdc_bit_sync.sv - single-bit multi-flop synchroniser with synchronous active-low reset
module cdc_bit_sync
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability settling time, so clamp up.
  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a toggle req/ack handshake carrying a WIDTH-bit word
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_src,
  input  logic             rst_src_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             ack_async,
  output logic             done,
  output logic             busy,
  output logic             err_timeout
);

  localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  cdc_state_e    state;
  logic          ack_s;
  logic [CW-1:0] wait_cnt;

  cdc_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk_src),
    .rst_n(rst_src_n),
    .d    (ack_async),
    .q    (ack_s)
  );

  // A phase mismatch in IDLE (spurious ack or unreset destination) blocks new words.
  assign in_ready = (state == IDLE) && (ack_s == xfer_req);
  assign busy     = (state == WAIT_ACK);

  always_ff @(posedge clk_src) begin
    if (!rst_src_n) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xfer_data <= in_data;
            xfer_req  <= ~xfer_req;
            wait_cnt  <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == xfer_req) begin
            state    <= IDLE;
            done     <= 1'b1;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            // Flag only; the word stays posted and a late ack still completes it.
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
              err_timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed and randomized checks of cdc_handshake_tx against a behavioural model
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;

  logic             clk_src = 1'b0;
  logic             rst_src_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             xfer_req;
  logic [WIDTH-1:0] xfer_data;
  logic             ack_async;
  logic             done;
  logic             busy;
  logic             err_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Model: ack as seen by the source is ack_async delayed by SYNC clock edges.
  bit             m_req;
  logic [WIDTH-1:0] m_data;
  bit             m_busy;
  bit             m_done;
  bit             m_err;
  int             m_wait;
  bit             m_hist[$];

  cdc_handshake_tx #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_src    (clk_src),
    .rst_src_n  (rst_src_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .ack_async  (ack_async),
    .done       (done),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk_src = ~clk_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    bit ready;
    if (!rst_src_n) begin
      m_req  = 1'b0;
      m_data = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_wait = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(1'b0);
      return;
    end
    ready  = !m_busy && (m_hist[0] == m_req);
    m_done = 1'b0;
    if (!m_busy) begin
      if (in_valid && ready) begin
        m_req  = ~m_req;
        m_data = in_data;
        m_busy = 1'b1;
        m_wait = 0;
      end
    end else if (m_hist[0] == m_req) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end else begin
      m_wait++;
      if (m_wait >= TMO) m_err = 1'b1;
    end
    m_hist.push_back(ack_async);
    void'(m_hist.pop_front());
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy && (m_hist[0] == m_req)});
    chk("xfer_req", {31'b0, xfer_req}, {31'b0, m_req});
    chk("xfer_data", {24'b0, xfer_data}, {24'b0, m_data});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_src);
    #1;
    check_all();
  endtask

  task automatic reset_dut();
    rst_src_n = 1'b0;
    in_valid  = 1'b0;
    ack_async = 1'b0;
    repeat (2) cyc();
    rst_src_n = 1'b1;
  endtask

  initial begin
    bit req_seen;
    int dly;

    repeat (SYNC) m_hist.push_back(1'b0);
    rst_src_n = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    ack_async = 1'b0;

    // Reset held with in_valid high, then a single A5 transfer.
    repeat (3) cyc();
    rst_src_n = 1'b1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_xfer_req", {31'b0, xfer_req}, 32'd0);
    chk("rst_xfer_data", {24'b0, xfer_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    cyc();
    in_valid = 1'b0;
    chk("single_req", {31'b0, xfer_req}, 32'd1);
    chk("single_data", {24'b0, xfer_data}, 32'hA5);
    repeat (3) cyc();
    ack_async = 1'b1;
    repeat (2) cyc();
    chk("single_no_early_done", {31'b0, done}, 32'd0);
    cyc();
    chk("single_done_c7", {31'b0, done}, 32'd1);
    chk("single_ready_c7", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("single_done_one_cycle", {31'b0, done}, 32'd0);

    // Back-to-back 11 then 22 with in_valid held.
    reset_dut();
    in_valid = 1'b1;
    in_data  = 8'h11;
    cyc();
    chk("b2b_req1", {31'b0, xfer_req}, 32'd1);
    in_data = 8'h22;
    repeat (5) cyc();
    ack_async = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("b2b_data_hold", {24'b0, xfer_data}, 32'h11);
    end
    cyc();
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_ready_on_done", {31'b0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("b2b_req2", {31'b0, xfer_req}, 32'd0);
    chk("b2b_data2", {24'b0, xfer_data}, 32'h22);
    repeat (4) cyc();
    ack_async = 1'b0;
    repeat (3) cyc();
    chk("b2b_done2", {31'b0, done}, 32'd1);

    // Stall: data churns upstream while the posted word must hold.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    cyc();
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom);
      cyc();
      chk("stall_data", {24'b0, xfer_data}, 32'h3C);
      chk("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    ack_async = 1'b1;
    repeat (3) cyc();
    chk("stall_done", {31'b0, done}, 32'd1);

    // Timeout: no ack for TMO cycles, then a late ack.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    cyc();
    in_valid = 1'b0;
    repeat (TMO - 1) cyc();
    chk("tmo_not_yet", {31'b0, err_timeout}, 32'd0);
    cyc();
    chk("tmo_err", {31'b0, err_timeout}, 32'd1);
    chk("tmo_busy", {31'b0, busy}, 32'd1);
    repeat (4) cyc();
    ack_async = 1'b0;
    repeat (3) cyc();
    chk("tmo_late_done", {31'b0, done}, 32'd1);
    chk("tmo_err_sticky", {31'b0, err_timeout}, 32'd1);

    // Reset mid-transfer while the destination keeps ack at 1.
    in_valid = 1'b1;
    in_data  = 8'h77;
    cyc();
    in_valid  = 1'b0;
    ack_async = 1'b1;
    cyc();
    rst_src_n = 1'b0;
    repeat (2) cyc();
    rst_src_n = 1'b1;
    repeat (SYNC) cyc();
    chk("midrst_req", {31'b0, xfer_req}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_err_clr", {31'b0, err_timeout}, 32'd0);
    ack_async = 1'b0;
    cyc();
    chk("midrst_ready_wait", {31'b0, in_ready}, 32'd0);
    cyc();
    chk("midrst_ready_back", {31'b0, in_ready}, 32'd1);

    // Spurious ack toggle in IDLE.
    ack_async = 1'b1;
    repeat (2) cyc();
    chk("spur_ready", {31'b0, in_ready}, 32'd0);
    chk("spur_done", {31'b0, done}, 32'd0);
    ack_async = 1'b0;
    repeat (2) cyc();
    chk("spur_recover", {31'b0, in_ready}, 32'd1);

    // Randomized traffic with a destination that mirrors req after a random delay.
    reset_dut();
    req_seen = 1'b0;
    dly      = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (xfer_req != req_seen) begin
        req_seen = xfer_req;
        dly      = $urandom_range(0, 20);
      end
      if (ack_async != xfer_req) begin
        if (dly == 0) ack_async = xfer_req;
        else dly--;
      end else if (!busy && ($urandom_range(0, 63) == 0)) begin
        ack_async = ~ack_async;
        dly       = $urandom_range(0, 4);
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
